snn_lif_layer_seq: RTL

Time-multiplexed leaky-integrate-and-fire layer for the spiking-network core. It is the parametrised successor of the parallel per-neuron layers.
- One shared accumulate/batchnorm/leak datapath evaluates NEURONS neurons sequentially, one neuron per clock.
- Membrane potentials are held in a register file.
- Carries its own byte-serial configuration port for weights, batchnorm params, threshold and leak shift.
- Sits between the input/previous-layer spike register and the next layer, with a start/done handshake.

---
 rtl/snn_lif_layer_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/snn_lif_layer_seq.sv
// Time-multiplexed leaky-integrate-and-fire layer: one shared datapath evaluates one neuron per clock.
// Define SNN_SATURATE_EN to clamp membrane potentials instead of wrapping them.
module snn_lif_layer_seq #(
    parameter int INPUTS         = 16,
    parameter int NEURONS        = 16,
    parameter int MEM_BITS       = 10,
    parameter int THRESHOLD_BITS = 5,
    parameter int THRESHOLD_INIT = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [INPUTS-1:0]  in_spikes,
    input  logic               cfg_valid,
    input  logic [1:0]         cfg_sel,
    input  logic [7:0]         cfg_data,
    output logic               cfg_ready,
    output logic               busy,
    output logic               done,
    output logic [NEURONS-1:0] out_spikes
);
    localparam int W     = INPUTS * NEURONS;
    localparam int B     = NEURONS * 8;
    localparam int IDX_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    // Wide enough that sum*factor, leak and addend never overflow before reduction.
    localparam int ACC_W = MEM_BITS + $clog2(INPUTS) + 8;
    localparam logic [THRESHOLD_BITS-1:0] THR_INIT = THRESHOLD_BITS'(THRESHOLD_INIT);
    localparam logic signed [ACC_W-1:0] ONE = {{(ACC_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state_q;
    logic [IDX_W-1:0]           idx_q;
    logic                       busy_q;
    logic                       done_q;
    logic [NEURONS-1:0]         out_spikes_q;
    logic [NEURONS-1:0]         work_q;
    logic [INPUTS-1:0]          spk_in_q;
    logic [W-1:0]               weights_q;
    logic [B-1:0]               bn_q;
    logic [THRESHOLD_BITS-1:0]  thr_q;
    logic [2:0]                 shift_q;
    logic signed [MEM_BITS-1:0] mem_q [NEURONS];

    function automatic logic signed [MEM_BITS-1:0] reduce(input logic signed [ACC_W-1:0] v);
`ifdef SNN_SATURATE_EN
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = {{(ACC_W-MEM_BITS+1){1'b0}}, {(MEM_BITS-1){1'b1}}};
        lo = {{(ACC_W-MEM_BITS+1){1'b1}}, {(MEM_BITS-1){1'b0}}};
        if (v > hi)
            reduce = hi[MEM_BITS-1:0];
        else if (v < lo)
            reduce = lo[MEM_BITS-1:0];
        else
            reduce = v[MEM_BITS-1:0];
`else
        reduce = v[MEM_BITS-1:0];
`endif
    endfunction

    logic [INPUTS-1:0]          w_row;
    logic [7:0]                 bn_byte;
    logic signed [ACC_W-1:0]    sum_d;
    logic signed [ACC_W-1:0]    factor_d;
    logic signed [ACC_W-1:0]    addend_d;
    logic signed [ACC_W-1:0]    scaled_d;
    logic signed [ACC_W-1:0]    u_ext;
    logic signed [ACC_W-1:0]    leak_d;
    logic signed [ACC_W-1:0]    u_new_ext;
    logic signed [ACC_W-1:0]    thr_ext;
    logic signed [MEM_BITS-1:0] u_new;
    logic signed [MEM_BITS-1:0] mem_d;
    logic                       spike_d;
    logic [NEURONS-1:0]         work_d;

    always_comb begin
        w_row    = weights_q[int'(idx_q) * INPUTS +: INPUTS];
        bn_byte  = bn_q[int'(idx_q) * 8 +: 8];
        sum_d    = '0;
        for (int j = 0; j < INPUTS; j++) begin
            if (spk_in_q[j]) begin
                if (w_row[j])
                    sum_d = sum_d + ONE;
                else
                    sum_d = sum_d - ONE;
            end
        end
        // Low nibble is an unsigned factor, high nibble a signed addend.
        factor_d  = {{(ACC_W-4){1'b0}}, bn_byte[3:0]};
        addend_d  = {{(ACC_W-4){bn_byte[7]}}, bn_byte[7:4]};
        scaled_d  = ((sum_d * factor_d) >>> 1) + addend_d;
        u_ext     = {{(ACC_W-MEM_BITS){mem_q[idx_q][MEM_BITS-1]}}, mem_q[idx_q]};
        leak_d    = u_ext >>> shift_q;
        u_new     = reduce(u_ext - leak_d + scaled_d);
        u_new_ext = {{(ACC_W-MEM_BITS){u_new[MEM_BITS-1]}}, u_new};
        thr_ext   = {{(ACC_W-THRESHOLD_BITS){1'b0}}, thr_q};
        spike_d   = (u_new_ext >= thr_ext);
        mem_d     = spike_d ? reduce(u_new_ext - thr_ext) : u_new;
        work_d         = work_q;
        work_d[idx_q]  = spike_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            out_spikes_q <= '0;
            work_q       <= '0;
            spk_in_q     <= '0;
            weights_q    <= '1;
            bn_q         <= {NEURONS{8'h02}};
            thr_q        <= THR_INIT;
            shift_q      <= 3'd4;
            for (int i = 0; i < NEURONS; i++)
                mem_q[i] <= '0;
        end else begin
            if (cfg_valid && !busy_q) begin
                case (cfg_sel)
                    2'd0:    weights_q <= {cfg_data, weights_q[W-1:8]};
                    2'd1:    bn_q      <= {cfg_data, bn_q[B-1:8]};
                    2'd2:    thr_q     <= cfg_data[THRESHOLD_BITS-1:0];
                    default: shift_q   <= cfg_data[2:0];
                endcase
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        spk_in_q <= in_spikes;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    mem_q[idx_q] <= mem_d;
                    work_q       <= work_d;
                    idx_q        <= idx_q + 1'b1;
                    // Outputs are registered, so they are set on entry to DONE.
                    if (idx_q == IDX_W'(NEURONS - 1)) begin
                        state_q      <= DONE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        out_spikes_q <= work_d;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign cfg_ready  = !busy_q;
    assign done       = done_q;
    assign out_spikes = out_spikes_q;

endmodule
